jtag_master: RTL and testbench
==============================

JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 SHALL have parameter DW, default 32, the maximum scan length in bits.
REQ-002 SHALL have parameter LW, default 6, the width of the length field; LW SHALL satisfy 2^LW > DW.
REQ-003 SHALL have port ck, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: command strobe, sampled only when busy=0.
REQ-006 SHALL have port cmd, input, 2 bits: 00 = DR scan, 01 = IR scan, 10 = TAP reset, 11 = reserved (no-op).
REQ-007 SHALL have port len, input, LW bits: number of bits to shift, 1..DW.
REQ-008 SHALL have port wdata, input, DW bits: data for TDI, shifted LSB first.
REQ-009 SHALL have port rdata, output, DW bits: captured TDO; bit i = TDO sampled during shift bit i.
REQ-010 SHALL have port busy, output, 1 bit: high while a command is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-ck pulse at command completion.
REQ-012 SHALL have port TCK, output, 1 bit: test clock.
REQ-013 SHALL have port TMS, output, 1 bit: test mode select.
REQ-014 SHALL have port TDI, output, 1 bit: scan data to the target.
REQ-015 SHALL have port TDO, input, 1 bit: scan data from the target.

Function
REQ-016 TCK SHALL be ck/2 while busy: it toggles every ck, starts low, and each command begins with a rising edge.
REQ-017 TCK SHALL be held low while idle.
REQ-018 TMS and TDI SHALL change only on the ck edge that drives TCK low.
REQ-019 TDO SHALL be sampled only on the ck edge that drives TCK high.
REQ-020 A command SHALL be accepted on a ck edge with start=1 and busy=0; cmd, len and wdata are registered at that edge, and busy rises at that edge.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 The internal TAP model SHALL track the 16 IEEE 1149.1 states and return to Run-Test/Idle after every command.
REQ-023 DR scan TMS sequence per TCK: 1,0,0 (to Shift-DR), then len bits with TMS=0 except the last bit TMS=1, then 1,0 (Update-DR, Idle). Total is len+5 TCK periods.
REQ-024 IR scan SHALL use the same sequence with an extra leading 1 (Select-IR). Total is len+6 TCK periods.
REQ-025 TAP reset SHALL drive TMS=1 for 5 TCK periods, then TMS=0 for 1 period. Total is 6 TCK periods; TDI is don't-care and driven 0.
REQ-026 TDI SHALL present wdata[i] during shift bit i; TDI SHALL be 0 outside shift states.
REQ-027 rdata bits at or above len SHALL be 0 at completion; rdata SHALL only update when a scan completes.
REQ-028 A command with len=0 or len>DW, or cmd=11, SHALL produce no TCK edges and no rdata change; busy is high for 1 ck and done pulses on the next ck.
REQ-029 done SHALL pulse on the ck edge after the final TCK falling edge; busy SHALL fall on that same edge.
REQ-030 A new start MAY be accepted on the cycle after done.

Reset
REQ-031 While reset=1 (asynchronous): TCK=0, TMS=1, TDI=0, busy=0, done=0, rdata=0, internal TAP model = Test-Logic-Reset.
REQ-032 The first command after reset SHALL begin from Test-Logic-Reset, preceded by one TCK with TMS=0 to reach Run-Test/Idle. This adds 1 TCK period.
REQ-033 Reset asserted mid-command SHALL abort immediately with no done pulse.

Verification
REQ-034 Reset, then cmd=10 → TMS pattern 0,1,1,1,1,1,0 over 7 TCK periods; done after 14 ck; busy falls with done.
REQ-035 IR scan, len=2, wdata=2'b10, target IR model in loop → TMS 1,1,0,0,0,1,1,0; TDI 0,0,0,0,0,1,0,0; rdata[1:0]=2'b01 (capture value).
REQ-036 DR scan, len=32, wdata=0xA5A5_5A5A, TDO tied to a 32-bit SFF chain preloaded 0x1234_5678 → rdata=0x1234_5678; chain holds 0xA5A5_5A5A after Update-DR; 37 TCK periods.
REQ-037 DR scan, len=1 → Shift-DR and Exit1 entered on the same bit (TMS=1 on the only shift bit); rdata[31:1]=0.
REQ-038 start held high continuously with len=0, then len=8 → error command completes in 2 ck; second command is not accepted until the cycle after done; start ignored while busy.
REQ-039 Reset asserted at shift bit 10 of a 32-bit DR scan → outputs at reset values within the same cycle; no done; next command includes the Idle prefix TCK.

Source files
------------

// File: rtl/jtag_master.sv
// JTAG master: issues DR scans, IR scans and TAP resets on a ck/2 test clock.
// It keeps a model of the target TAP controller so that the first command
// after reset can add the extra TCK needed to leave Test-Logic-Reset.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | TCK held low, waiting for a start strobe
//   S_PRE   | one TCK with TMS=0 to move Test-Logic-Reset -> Run-Test/Idle
//   S_HDR   | walk from Run-Test/Idle into Shift-DR/IR (3 or 4 TCKs)
//   S_SHIFT | len data bits, TMS=1 on the last one (into Exit1)
//   S_TAIL  | Update then back to Run-Test/Idle (2 TCKs)
//   S_TRST  | five TMS=1 TCKs then one TMS=0 TCK
//   S_DONE  | last TCK is low; done pulses and busy falls at the next edge
module jtag_master #(
    parameter int DW = 32,
    parameter int LW = 6
) (
    input  logic          ck,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    cmd,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          done,
    output logic          TCK,
    output logic          TMS,
    output logic          TDI,
    input  logic          TDO
);

    // The counter also sequences the fixed-length phases, which need 3 bits.
    localparam int CW = (LW > 3) ? LW : 3;
    localparam logic [LW-1:0] DW_L = LW'(DW);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_HDR, S_SHIFT, S_TAIL, S_TRST, S_DONE
    } st_t;

    typedef enum logic [3:0] {
        TAP_TLR, TAP_RTI, TAP_SELDR, TAP_CAPDR, TAP_SHDR, TAP_EX1DR,
        TAP_PADR, TAP_EX2DR, TAP_UPDR, TAP_SELIR, TAP_CAPIR, TAP_SHIR,
        TAP_EX1IR, TAP_PAIR, TAP_EX2IR, TAP_UPIR
    } tap_t;

    st_t           state_q, state_d;
    tap_t          tap_q, tap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cap_q, cap_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          scan_q, scan_d;
    logic          tck_q, tck_d;
    logic          tms_q, tms_d;
    logic          tdi_q, tdi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        tap_t n;
        n = TAP_TLR;
        case (s)
            TAP_TLR:   n = m ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   n = m ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: n = m ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: n = m ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  n = m ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: n = m ? TAP_UPDR  : TAP_PADR;
            TAP_PADR:  n = m ? TAP_EX2DR : TAP_PADR;
            TAP_EX2DR: n = m ? TAP_UPDR  : TAP_SHDR;
            TAP_UPDR:  n = m ? TAP_SELDR : TAP_RTI;
            TAP_SELIR: n = m ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: n = m ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  n = m ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: n = m ? TAP_UPIR  : TAP_PAIR;
            TAP_PAIR:  n = m ? TAP_EX2IR : TAP_PAIR;
            TAP_EX2IR: n = m ? TAP_UPIR  : TAP_SHIR;
            TAP_UPIR:  n = m ? TAP_SELDR : TAP_RTI;
            default:   n = TAP_TLR;
        endcase
        return n;
    endfunction

    // TMS value for TCK period (st, c) of a command.
    function automatic logic period_tms(input st_t st, input logic [CW-1:0] c,
                                        input logic ir, input logic [LW-1:0] l);
        logic r;
        r = 1'b0;
        case (st)
            S_HDR:   r = ir ? (c < CW'(2)) : (c == '0);
            S_SHIFT: r = (c == CW'(l) - CW'(1));
            S_TAIL:  r = (c == '0);
            S_TRST:  r = (c < CW'(5));
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic period_tdi(input st_t st, input logic [CW-1:0] c,
                                        input logic [DW-1:0] w);
        logic [DW-1:0] sh;
        sh = w >> c;
        return (st == S_SHIFT) ? sh[0] : 1'b0;
    endfunction

    // Next-state, TCK phase and scan datapath.
    always_comb begin
        logic          valid;
        st_t           nst;
        logic [CW-1:0] ncnt;
        logic [CW-1:0] last;

        state_d = state_q;
        tap_d   = tap_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        scan_d  = scan_q;
        tck_d   = tck_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid   = 1'b0;
        nst     = state_q;
        ncnt    = cnt_q;
        last    = '0;

        case (state_q)
            S_IDLE: begin
                tck_d = 1'b0;
                if (start) begin
                    cmd_d   = cmd;
                    len_d   = len;
                    wdata_d = wdata;
                    cap_d   = '0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    valid   = cmd[1] ? (cmd == 2'b10)
                                     : ((len != '0) && (len <= DW_L));
                    scan_d  = valid && !cmd[1];
                    if (!valid) begin
                        state_d = S_DONE;
                    end else begin
                        if (tap_q == TAP_TLR)
                            nst = S_PRE;
                        else if (cmd == 2'b10)
                            nst = S_TRST;
                        else
                            nst = S_HDR;
                        state_d = nst;
                        tms_d   = period_tms(nst, '0, cmd[0], len);
                        tdi_d   = period_tdi(nst, '0, wdata);
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (scan_q)
                    rdata_d = cap_q;
            end
            default: begin
                if (!tck_q) begin
                    // Rising TCK: the target TAP advances, TDO is sampled.
                    tck_d = 1'b1;
                    tap_d = tap_next(tap_q, tms_q);
                    if (state_q == S_SHIFT)
                        cap_d = cap_q | (DW'(TDO) << cnt_q);
                end else begin
                    // Falling TCK: move to the next period and present its TMS/TDI.
                    tck_d = 1'b0;
                    ncnt  = cnt_q + CW'(1);
                    case (state_q)
                        S_PRE: begin
                            nst  = (cmd_q == 2'b10) ? S_TRST : S_HDR;
                            ncnt = '0;
                        end
                        S_HDR: begin
                            last = cmd_q[0] ? CW'(3) : CW'(2);
                            if (cnt_q == last) begin
                                nst  = S_SHIFT;
                                ncnt = '0;
                            end
                        end
                        S_SHIFT: begin
                            if (cnt_q == CW'(len_q) - CW'(1)) begin
                                nst  = S_TAIL;
                                ncnt = '0;
                            end
                        end
                        S_TAIL: begin
                            if (cnt_q == CW'(1))
                                nst = S_DONE;
                        end
                        S_TRST: begin
                            if (cnt_q == CW'(5))
                                nst = S_DONE;
                        end
                        default: nst = S_DONE;
                    endcase
                    state_d = nst;
                    cnt_d   = ncnt;
                    tms_d   = period_tms(nst, ncnt, cmd_q[0], len_q);
                    tdi_d   = period_tdi(nst, ncnt, wdata_q);
                end
            end
        endcase
    end

    // State register; reset aborts any command and parks the TAP model in Test-Logic-Reset.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tap_q   <= TAP_TLR;
            cnt_q   <= '0;
            cmd_q   <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
            scan_q  <= 1'b0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
            scan_q  <= scan_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign TCK   = tck_q;
    assign TMS   = tms_q;
    assign TDI   = tdi_q;

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master with a small behavioural JTAG target:
// 2-bit IR (captures 01) and a 32-bit DR shift chain that holds its value on capture.
module tb_jtag_master;

    logic        ck = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic [5:0]  len = 6'd0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        busy, done, TCK, TMS, TDI;
    logic        TDO = 1'b0;

    int nchk = 0;
    int nerr = 0;

    jtag_master #(.DW(32), .LW(6)) dut (
        .ck(ck), .reset(reset), .start(start), .cmd(cmd), .len(len),
        .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    always #5 ck = ~ck;

    // Target TAP state encoding.
    localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SELDR = 4'd2, CAPDR = 4'd3,
        SHDR = 4'd4, EX1DR = 4'd5, PADR = 4'd6, EX2DR = 4'd7, UPDR = 4'd8,
        SELIR = 4'd9, CAPIR = 4'd10, SHIR = 4'd11, EX1IR = 4'd12, PAIR = 4'd13,
        EX2IR = 4'd14, UPIR = 4'd15;

    function automatic logic [3:0] tnext(input logic [3:0] s, input logic m);
        logic [3:0] n;
        n = TLR;
        case (s)
            TLR:   n = m ? TLR   : RTI;
            RTI:   n = m ? SELDR : RTI;
            SELDR: n = m ? SELIR : CAPDR;
            CAPDR: n = m ? EX1DR : SHDR;
            SHDR:  n = m ? EX1DR : SHDR;
            EX1DR: n = m ? UPDR  : PADR;
            PADR:  n = m ? EX2DR : PADR;
            EX2DR: n = m ? UPDR  : SHDR;
            UPDR:  n = m ? SELDR : RTI;
            SELIR: n = m ? TLR   : CAPIR;
            CAPIR: n = m ? EX1IR : SHIR;
            SHIR:  n = m ? EX1IR : SHIR;
            EX1IR: n = m ? UPIR  : PAIR;
            PAIR:  n = m ? EX2IR : PAIR;
            EX2IR: n = m ? UPIR  : SHIR;
            UPIR:  n = m ? SELDR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

    logic [3:0]  t_st = TLR;
    logic [1:0]  ir_sh = 2'b00;
    logic [1:0]  ir = 2'b00;
    logic [31:0] dr = 32'h1234_5678;

    // Target: act on the TAP state at each rising TCK, then advance.
    always @(posedge TCK or posedge reset) begin
        if (reset) begin
            t_st <= TLR;
        end else begin
            case (t_st)
                CAPIR:   ir_sh <= 2'b01;
                SHIR:    ir_sh <= {TDI, ir_sh[1]};
                UPIR:    ir    <= ir_sh;
                SHDR:    dr    <= {TDI, dr[31:1]};
                default: ;
            endcase
            t_st <= tnext(t_st, TMS);
        end
    end

    // Target drives TDO on the falling TCK.
    always @(negedge TCK)
        TDO <= (t_st == SHIR) ? ir_sh[0] : (t_st == SHDR) ? dr[0] : 1'b0;

    // Record TMS/TDI as seen by the target at every rising TCK (earliest bit ends up highest).
    int          tck_total = 0;
    logic [63:0] tms_hist = '0;
    logic [63:0] tdi_hist = '0;
    always @(posedge TCK) begin
        tck_total <= tck_total + 1;
        tms_hist  <= {tms_hist[62:0], TMS};
        tdi_hist  <= {tdi_hist[62:0], TDI};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lowbits(input logic [63:0] v, input int n);
        return v & ((64'd1 << n) - 64'd1);
    endfunction

    // Issue one command; ncyc = ck edges from the accept edge to the edge raising done.
    task automatic do_cmd(input string tag, input logic [1:0] c, input logic [5:0] l,
                          input logic [31:0] w, output int ncyc, output int nper);
        int base;
        int n;
        @(negedge ck);
        cmd = c; len = l; wdata = w; start = 1'b1;
        base = tck_total;
        @(posedge ck); #1;
        start = 1'b0;
        chk({tag, "_busy_acc"}, busy, 1'b1);
        n = 0;
        while (!done && n < 200) begin
            @(posedge ck); #1;
            n++;
        end
        if (!done) chk({tag, "_timeout"}, 1'b0, 1'b1);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        ncyc = n;
        nper = tck_total - base;
    endtask

    int ncyc, nper, base, n;
    logic saw_done;

    initial begin
        // Reset values.
        #12;
        chk("rst_tck", TCK, 1'b0);
        chk("rst_tms", TMS, 1'b1);
        chk("rst_tdi", TDI, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        @(negedge ck); reset = 1'b0;

        // TAP reset straight after reset: Idle prefix + 5x1 + 0. The first TCK rises one
        // ck after accept, so done lands 14 ck after that first rise (15 after accept).
        do_cmd("trst", 2'b10, 6'd0, 32'h0, ncyc, nper);
        chk("trst_periods", nper, 7);
        chk("trst_cycles", ncyc, 15);
        chk("trst_tms", lowbits(tms_hist, 7), 64'b0111110);
        chk("trst_tdi", lowbits(tdi_hist, 7), 64'b0);

        // IR scan, 2 bits of 10; target captures 01.
        do_cmd("ir2", 2'b01, 6'd2, 32'h2, ncyc, nper);
        chk("ir2_periods", nper, 8);
        chk("ir2_cycles", ncyc, 17);
        chk("ir2_tms", lowbits(tms_hist, 8), 64'b11000110);
        chk("ir2_tdi", lowbits(tdi_hist, 8), 64'b00000100);
        chk("ir2_rdata", rdata, 32'h1);
        chk("ir2_target_ir", ir, 2'b10);

        // Full-width DR scan through the preloaded chain.
        do_cmd("dr32", 2'b00, 6'd32, 32'hA5A5_5A5A, ncyc, nper);
        chk("dr32_periods", nper, 37);
        chk("dr32_cycles", ncyc, 75);
        chk("dr32_rdata", rdata, 32'h1234_5678);
        chk("dr32_chain", dr, 32'hA5A5_5A5A);

        // Single-bit DR scan: chain bit0 is 0, stale upper rdata must clear.
        do_cmd("dr1a", 2'b00, 6'd1, 32'h1, ncyc, nper);
        chk("dr1a_periods", nper, 6);
        chk("dr1a_cycles", ncyc, 13);
        chk("dr1a_tms", lowbits(tms_hist, 6), 64'b100110);
        chk("dr1a_tdi", lowbits(tdi_hist, 6), 64'b000100);
        chk("dr1a_rdata", rdata, 32'h0);
        chk("dr1a_chain", dr, 32'hD2D2_AD2D);
        do_cmd("dr1b", 2'b00, 6'd1, 32'h0, ncyc, nper);
        chk("dr1b_rdata", rdata, 32'h1);

        // start held high: len=0 error command, then an 8-bit DR scan.
        @(negedge ck);
        cmd = 2'b00; len = 6'd0; wdata = 32'h0; start = 1'b1;
        base = tck_total;
        @(posedge ck); #1;
        chk("err_busy", busy, 1'b1);
        len = 6'd8; wdata = 32'h3C;
        @(posedge ck); #1;
        chk("err_done", done, 1'b1);
        chk("err_busy_fall", busy, 1'b0);
        chk("err_rdata", rdata, 32'h1);
        chk("err_no_tck", tck_total - base, 0);
        @(posedge ck); #1;
        chk("held_accept", busy, 1'b1);
        chk("held_done_low", done, 1'b0);
        base = tck_total;
        cmd = 2'b10; len = 6'd3;
        repeat (4) @(posedge ck);
        #1; start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(posedge ck); #1;
            n++;
        end
        if (!done) chk("dr8_timeout", 1'b0, 1'b1);
        chk("dr8_periods", tck_total - base, 13);
        chk("dr8_tms", lowbits(tms_hist, 13), 64'b1000000000110);
        chk("dr8_rdata", rdata, 32'h96);
        chk("dr8_chain", dr, 32'h3C69_6956);

        // Reset during shift bit 10 of a 32-bit DR scan.
        @(negedge ck);
        cmd = 2'b00; len = 6'd32; wdata = 32'hFFFF_0000; start = 1'b1;
        @(posedge ck); #1;
        start = 1'b0;
        base = tck_total;
        n = 0;
        while ((tck_total - base) < 14 && n < 100) begin
            @(posedge ck); #1;
            n++;
        end
        chk("mid_reach", tck_total - base, 14);
        chk("mid_tck_high", TCK, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mid_tck", TCK, 1'b0);
        chk("mid_tms", TMS, 1'b1);
        chk("mid_tdi", TDI, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_rdata", rdata, 32'h0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge ck); #1;
            saw_done = saw_done | done;
        end
        @(negedge ck); reset = 1'b0;
        repeat (3) begin
            @(posedge ck); #1;
            saw_done = saw_done | done;
        end
        chk("mid_no_done", saw_done, 1'b0);
        do_cmd("post", 2'b10, 6'd0, 32'h0, ncyc, nper);
        chk("post_periods", nper, 7);
        chk("post_cycles", ncyc, 15);
        chk("post_tms", lowbits(tms_hist, 7), 64'b0111110);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
        $finish;
    end

endmodule
